axi_sram_responder: RTL and testbench
=====================================

# axi_sram_responder

AXI3 slave memory model that answers the read and write bursts issued by the CPU top's bus master, so the core can be simulated without the external SoC RAM. It sits on the slave side of the CPU's AXI port, backed by a word-addressed on-chip array. It serves one transaction at a time and inserts a programmable read latency. The `arlock/arcache/arprot`, `awlock/awcache/awprot` and `wid` sideband signals are not ports; the instantiator leaves them unconnected.

## Interface
- `MEM_WORDS`, 1024: array depth in 32-bit words; byte range is [0, MEM_WORDS*4).
- `LATENCY`, 2: idle cycles (≥0) between the AR handshake and the first `rvalid`.
- `aclk` in 1: clock, all state on rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `arid` in 4: read ID, returned on `rid`. `araddr` in 32: read start byte address. `arlen` in 4: beats-1. `arvalid` in 1. `arready` out 1.
- `rid` out 4. `rdata` out 32. `rresp` out 2: 00 OKAY, 11 DECERR. `rlast` out 1. `rvalid` out 1. `rready` in 1.
- `awid` in 4. `awaddr` in 32. `awlen` in 4. `awvalid` in 1. `awready` out 1.
- `wdata` in 32. `wstrb` in 4: byte enables. `wlast` in 1. `wvalid` in 1. `wready` out 1.
- `bid` out 4. `bresp` out 2: 00 OKAY, 10 SLVERR, 11 DECERR. `bvalid` out 1. `bready` in 1.

## Operation
- All beats are 4 bytes and all bursts are INCR. `arsize/awsize/arburst/awburst` are not ports. The beat address advances by 4 per beat. `addr[1:0]` is ignored for indexing.
- FSM states: IDLE, RWAIT, RDATA, WDATA, WRESP. Memory contents are not cleared by reset.
- IDLE: `arready = ~(awvalid & pref_w)` and `awready = ~(arvalid & ~pref_w)`. Both are 0 in every other state. When both valids are high, exactly one is granted.
- `pref_w` is a round-robin bit, reset 0 (read wins). It is set to 1 on each AR grant and cleared to 0 on each AW grant.
- AR handshake: latch `arid`, the address and the beat count. Go to RWAIT with the counter set to `LATENCY`, or straight to RDATA when `LATENCY`=0.
- RWAIT: decrement the counter and enter RDATA when it reaches 0.
- RDATA: `rvalid`=1. `rdata` is mem[addr>>2], or 0 with `rresp`=11 when addr>>2 ≥ `MEM_WORDS`. `rlast`=1 on the final beat.
  - On `rvalid&rready`, advance the address and count.
  - After the final beat, return to IDLE.
  - `rdata/rresp/rlast/rid` stay stable while `rready`=0.
- AW handshake: latch `awid`, the address and the beat count. Clear the error flags and go to WDATA.
- WDATA: `wready`=1. On each `wvalid` beat, write the bytes of mem[addr>>2] enabled by `wstrb`.
  - An out-of-range beat is dropped and sets the DECERR flag.
  - `wlast` not equal to (beat==final) sets the SLVERR flag.
  - After the final beat (by count, regardless of `wlast`), go to WRESP.
- WRESP: `bvalid`=1 and `bid`=latched ID. `bresp` is 11 if DECERR, else 10 if SLVERR, else 00. Return to IDLE on `bready`.
- Reset values: state IDLE, `pref_w`=0. `rvalid`, `rlast`, `wready` and `bvalid` are 0. `rdata`, `rresp`, `rid`, `bid` and `bresp` are 0. `arready` and `awready` are 1 while their valids are low.
- Reset asserted mid-burst aborts the burst immediately. Writes already performed persist.

## Timing
- AR handshake at cycle T: the first `rvalid` is at T+1+`LATENCY`. With `rready` held high, subsequent beats come one per cycle.
- AW handshake at T: `wready` is high from T+1. With the last W handshake at U, `bvalid` is at U+1.
- Final R or B handshake at V: IDLE at V+1, and `arready/awready` can be high in V+1.
- Never more than one transaction outstanding. The memory write takes effect at the edge of the W handshake, so a read granted afterwards returns the new data.

## Test plan
- Reset: hold `aresetn`=0 for 3 cycles. Required: `rvalid`/`bvalid`/`wready`=0 and `arready`=`awready`=1.
- Single write then read: AW addr 0x10, len 0, wdata 0xDEADBEEF, wstrb 1111 gives `bresp` 00. Then AR 0x10, `LATENCY`=2, handshake at T gives `rvalid` at T+3 with `rdata` 0xDEADBEEF, `rlast`=1, `rresp` 00.
- 4-beat burst with backpressure: write 0x100..0x10C with 1,2,3,4. Read len 3 with `rready` toggling 1,0,1,0. Required: data 1,2,3,4 in order, stable while stalled, `rlast` only on beat 4, `rid`=`arid`.
- Byte strobes and errors:
  - Write 0x11223344 then 0xAABBCCDD with `wstrb` 0101: readback must be 0x11BB33DD.
  - Read address `MEM_WORDS`*4: `rresp` 11, `rdata` 0.
  - Write len 1 with `wlast` on beat 0: `bresp` 10.
- Simultaneous `arvalid`&`awvalid` from reset: read granted first, write second. Repeat: write granted first, read second.
- Reset asserted during RDATA beat 2 of 4: outputs return to reset values asynchronously and the next AR is served normally.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI3 slave memory model: one transaction at a time, INCR bursts of 32-bit beats,
// backed by a word-addressed array, with a programmable idle gap before read data.
module axi_sram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int            IW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int            CW         = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [29:0]   WORD_LIMIT = 30'(MEM_WORDS);
  localparam logic [CW-1:0] LAT_INIT   = CW'(LATENCY);

  typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [31:0]   r_mem [MEM_WORDS];
  logic [29:0]   r_wordAddr;
  logic [3:0]    r_beatsLeft;
  logic [CW-1:0] r_latCnt;
  logic          r_prefW;
  logic          r_decErr;
  logic          r_slvErr;
  logic [3:0]    r_rid;
  logic [3:0]    r_bid;

  logic          w_arHs;
  logic          w_awHs;
  logic          w_rBeat;
  logic          w_wBeat;
  logic          w_finalBeat;
  logic          w_inRange;
  logic [IW-1:0] w_memIdx;
  logic          w_unused;

  // Byte offsets within a beat never affect indexing.
  assign w_unused    = &{1'b0, araddr[1:0], awaddr[1:0]};

  assign w_arHs      = arvalid & arready;
  assign w_awHs      = awvalid & awready;
  assign w_rBeat     = (r_state == RDATA) & rready;
  assign w_wBeat     = (r_state == WDATA) & wvalid;
  assign w_finalBeat = (r_beatsLeft == 4'd0);
  assign w_inRange   = (r_wordAddr < WORD_LIMIT);
  assign w_memIdx    = r_wordAddr[IW-1:0];
  assign rid         = r_rid;
  assign bid         = r_bid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_arHs) begin
          w_nextState = (LATENCY == 0) ? RDATA : RWAIT;
        end else if (w_awHs) begin
          w_nextState = WDATA;
        end
      end
      RWAIT: begin
        if (r_latCnt <= CW'(1)) begin
          w_nextState = RDATA;
        end
      end
      RDATA: begin
        if (w_rBeat && w_finalBeat) begin
          w_nextState = IDLE;
        end
      end
      WDATA: begin
        if (w_wBeat && w_finalBeat) begin
          w_nextState = WRESP;
        end
      end
      WRESP: begin
        if (bready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Round-robin grant: the side that did not win last time gets priority.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = 32'd0;
    rresp   = 2'b00;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    unique case (r_state)
      IDLE: begin
        arready = ~(awvalid & r_prefW);
        awready = ~(arvalid & ~r_prefW);
      end
      RDATA: begin
        rvalid = 1'b1;
        rlast  = w_finalBeat;
        rdata  = w_inRange ? r_mem[w_memIdx] : 32'd0;
        rresp  = w_inRange ? 2'b00 : 2'b11;
      end
      WDATA: begin
        wready = 1'b1;
      end
      WRESP: begin
        bvalid = 1'b1;
        bresp  = r_decErr ? 2'b11 : (r_slvErr ? 2'b10 : 2'b00);
      end
      default: begin
        arready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prefW     <= 1'b0;
      r_rid       <= 4'd0;
      r_bid       <= 4'd0;
      r_wordAddr  <= 30'd0;
      r_beatsLeft <= 4'd0;
      r_latCnt    <= '0;
      r_decErr    <= 1'b0;
      r_slvErr    <= 1'b0;
    end else begin
      if (w_arHs) begin
        r_prefW     <= 1'b1;
        r_rid       <= arid;
        r_wordAddr  <= araddr[31:2];
        r_beatsLeft <= arlen;
        r_latCnt    <= LAT_INIT;
      end else if (w_awHs) begin
        r_prefW     <= 1'b0;
        r_bid       <= awid;
        r_wordAddr  <= awaddr[31:2];
        r_beatsLeft <= awlen;
        r_decErr    <= 1'b0;
        r_slvErr    <= 1'b0;
      end
      if (r_state == RWAIT) begin
        r_latCnt <= r_latCnt - 1'b1;
      end
      if (w_rBeat || w_wBeat) begin
        r_wordAddr  <= r_wordAddr + 30'd1;
        r_beatsLeft <= r_beatsLeft - 4'd1;
      end
      if (w_wBeat) begin
        if (!w_inRange) begin
          r_decErr <= 1'b1;
        end
        if (wlast != w_finalBeat) begin
          r_slvErr <= 1'b1;
        end
      end
    end
  end

  // The array is deliberately left out of reset so contents survive it.
  always_ff @(posedge aclk) begin
    if (w_wBeat && w_inRange) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          r_mem[w_memIdx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a byte-level memory model feeds a queue
// of expected read beats and write responses that are checked as the DUT answers.
module tb_axi_sram_responder;

  localparam int MEM_WORDS = 1024;
  localparam int LATENCY   = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int          assertCount = 0;
  int          failCount   = 0;

  logic [31:0] model [MEM_WORDS];
  rexp_t       rExpQ[$];
  bexp_t       bExpQ[$];
  logic [31:0] wDataQ[$];
  logic [3:0]  wStrbQ[$];
  logic        wLastQ[$];

  axi_sram_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LATENCY  (LATENCY)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .arid   (arid),
    .araddr (araddr),
    .arlen  (arlen),
    .arvalid(arvalid),
    .arready(arready),
    .rid    (rid),
    .rdata  (rdata),
    .rresp  (rresp),
    .rlast  (rlast),
    .rvalid (rvalid),
    .rready (rready),
    .awid   (awid),
    .awaddr (awaddr),
    .awlen  (awlen),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wlast  (wlast),
    .wvalid (wvalid),
    .wready (wready),
    .bid    (bid),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Last-resort guard so a wedged DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    wDataQ.push_back(data);
    wStrbQ.push_back(strb);
    wLastQ.push_back(last);
  endtask

  task automatic applyReset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // Full write burst; the model and the expected B response are updated as beats go out.
  task automatic applyStimulusWrite(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int    n;
    int    idx;
    logic  dec;
    logic  slv;
    bexp_t e;
    dec     = 1'b0;
    slv     = 1'b0;
    idx     = int'(addr[31:2]);
    awid    = id;
    awaddr  = addr;
    awlen   = len;
    awvalid = 1'b1;
    n       = 0;
    #1;
    while (!awready && n < 20) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checkOutput("awReadyWait", 32'(n < 20), 32'd1);
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    checkOutput("wreadyAfterAw", 32'(wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata  = wDataQ.pop_front();
      wstrb  = wStrbQ.pop_front();
      wlast  = wLastQ.pop_front();
      wvalid = 1'b1;
      if (idx < MEM_WORDS) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        dec = 1'b1;
      end
      if (wlast != (i == int'(len))) slv = 1'b1;
      idx++;
      #1;
      checkOutput("wreadyBeat", 32'(wready), 32'd1);
      @(posedge aclk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bExpQ.push_back('{id: id, resp: dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
    #1;
    checkOutput("bvalid", 32'(bvalid), 32'd1);
    e = bExpQ.pop_front();
    checkOutput("bid", 32'(bid), 32'(e.id));
    checkOutput("bresp", 32'(bresp), 32'(e.resp));
    bready = 1'b1;
    @(posedge aclk);
    #1;
    bready = 1'b0;
    checkOutput("bvalidDrop", 32'(bvalid), 32'd0);
  endtask

  // AR handshake; expected beats are queued from the model at issue time.
  task automatic applyStimulusRead(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int    n;
    int    idx;
    rexp_t e;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arvalid = 1'b1;
    n       = 0;
    #1;
    while (!arready && n < 20) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checkOutput("arReadyWait", 32'(n < 20), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      idx    = int'(addr[31:2]) + i;
      e.data = (idx < MEM_WORDS) ? model[idx] : 32'd0;
      e.resp = (idx < MEM_WORDS) ? 2'b00 : 2'b11;
      e.last = (i == int'(len));
      e.id   = id;
      rExpQ.push_back(e);
    end
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
  endtask

  // Drain read beats; with stall set, rready alternates 1,0,1,0 on valid cycles.
  task automatic checkReadBeats(input int beats, input bit stall);
    int    got;
    int    guard;
    bit    rr;
    rexp_t e;
    got   = 0;
    guard = 0;
    rr    = 1'b1;
    while (got < beats && guard < 100) begin
      rready = rr;
      #1;
      if (rvalid) begin
        e = rExpQ[0];
        checkOutput("rdata", rdata, e.data);
        checkOutput("rresp", 32'(rresp), 32'(e.resp));
        checkOutput("rlast", 32'(rlast), 32'(e.last));
        checkOutput("rid", 32'(rid), 32'(e.id));
        if (rr) begin
          e = rExpQ.pop_front();
          got++;
        end
        if (stall) rr = ~rr;
      end
      @(posedge aclk);
      #1;
      guard++;
    end
    rready = 1'b0;
    checkOutput("readBeatCount", 32'(got), 32'(beats));
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awid    = '0;
    awaddr  = '0;
    awlen   = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;

    // Reset state, sampled while reset is still held.
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rstArready", 32'(arready), 32'd1);
    checkOutput("rstAwready", 32'(awready), 32'd1);
    checkOutput("rstRvalid", 32'(rvalid), 32'd0);
    checkOutput("rstBvalid", 32'(bvalid), 32'd0);
    checkOutput("rstWready", 32'(wready), 32'd0);
    checkOutput("rstRlast", 32'(rlast), 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    checkOutput("rstRresp", 32'(rresp), 32'd0);
    checkOutput("rstRid", 32'(rid), 32'd0);
    checkOutput("rstBid", 32'(bid), 32'd0);
    checkOutput("rstBresp", 32'(bresp), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    $display("[TB] single write then read with latency");
    pushBeat(32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulusWrite(4'd3, 32'h10, 4'd0);
    applyStimulusRead(4'd3, 32'h10, 4'd0);
    checkOutput("latT1", 32'(rvalid), 32'd0);
    @(posedge aclk);
    #1;
    checkOutput("latT2", 32'(rvalid), 32'd0);
    @(posedge aclk);
    #1;
    checkOutput("latT3", 32'(rvalid), 32'd1);
    checkReadBeats(1, 1'b0);
    checkOutput("arreadyAfterRead", 32'(arready), 32'd1);

    $display("[TB] 4-beat burst with backpressure");
    for (int i = 0; i < 4; i++) pushBeat(32'(i + 1), 4'hF, i == 3);
    applyStimulusWrite(4'd7, 32'h100, 4'd3);
    applyStimulusRead(4'd9, 32'h100, 4'd3);
    checkReadBeats(4, 1'b1);

    $display("[TB] byte strobes and error responses");
    pushBeat(32'h11223344, 4'hF, 1'b1);
    applyStimulusWrite(4'd1, 32'h40, 4'd0);
    pushBeat(32'hAABBCCDD, 4'b0101, 1'b1);
    applyStimulusWrite(4'd1, 32'h40, 4'd0);
    checkOutput("strobeModel", model[16], 32'h11BB33DD);
    applyStimulusRead(4'd2, 32'h40, 4'd0);
    checkReadBeats(1, 1'b0);
    applyStimulusRead(4'd6, 32'(MEM_WORDS * 4), 4'd0);
    checkReadBeats(1, 1'b0);
    pushBeat(32'h0BAD0001, 4'hF, 1'b1);
    pushBeat(32'h0BAD0002, 4'hF, 1'b0);
    applyStimulusWrite(4'd5, 32'h80, 4'd1);
    pushBeat(32'h12345678, 4'hF, 1'b1);
    applyStimulusWrite(4'd4, 32'(MEM_WORDS * 4), 4'd0);
    applyStimulusRead(4'd5, 32'h80, 4'd1);
    checkReadBeats(2, 1'b0);

    $display("[TB] simultaneous requests after reset");
    applyReset();
    arid    = 4'd5;
    araddr  = 32'h10;
    arlen   = 4'd0;
    arvalid = 1'b1;
    awid    = 4'd6;
    awaddr  = 32'h300;
    awlen   = 4'd0;
    awvalid = 1'b1;
    #1;
    checkOutput("grant1Ar", 32'(arready), 32'd1);
    checkOutput("grant1Aw", 32'(awready), 32'd0);
    applyStimulusRead(4'd5, 32'h10, 4'd0);
    checkReadBeats(1, 1'b0);
    checkOutput("grant1AwAfter", 32'(awready), 32'd1);
    pushBeat(32'h00000055, 4'hF, 1'b1);
    applyStimulusWrite(4'd6, 32'h300, 4'd0);
    applyStimulusRead(4'd2, 32'h300, 4'd0);
    checkReadBeats(1, 1'b0);
    arid    = 4'd4;
    araddr  = 32'h304;
    arlen   = 4'd0;
    arvalid = 1'b1;
    awid    = 4'd8;
    awaddr  = 32'h304;
    awlen   = 4'd0;
    awvalid = 1'b1;
    #1;
    checkOutput("grant2Aw", 32'(awready), 32'd1);
    checkOutput("grant2Ar", 32'(arready), 32'd0);
    pushBeat(32'h00000066, 4'hF, 1'b1);
    applyStimulusWrite(4'd8, 32'h304, 4'd0);
    #1;
    checkOutput("grant2ArAfter", 32'(arready), 32'd1);
    checkOutput("grant2AwBlocked", 32'(awready), 32'd0);
    applyStimulusRead(4'd4, 32'h304, 4'd0);
    checkReadBeats(1, 1'b0);

    $display("[TB] reset during read burst");
    for (int i = 0; i < 4; i++) pushBeat(32'hA0 + 32'(i), 4'hF, i == 3);
    applyStimulusWrite(4'd3, 32'h200, 4'd3);
    applyStimulusRead(4'd11, 32'h200, 4'd3);
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checkOutput("midRvalidWait", 32'(n < 20), 32'd1);
    @(posedge aclk);
    #1;
    checkOutput("midBeat2Data", rdata, rExpQ[1].data);
    aresetn = 1'b0;
    #1;
    checkOutput("midRstRvalid", 32'(rvalid), 32'd0);
    checkOutput("midRstRdata", rdata, 32'd0);
    checkOutput("midRstRlast", 32'(rlast), 32'd0);
    checkOutput("midRstRid", 32'(rid), 32'd0);
    checkOutput("midRstArready", 32'(arready), 32'd1);
    rready = 1'b0;
    rExpQ.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    applyStimulusRead(4'd12, 32'h204, 4'd0);
    checkReadBeats(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
